// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: baud indices, default divisors, FSM encoding.
// Divisors are clocks per bit at a 50 MHz core clock.
package uart_pkg;

  localparam logic [1:0] B200    = 2'b00;
  localparam logic [1:0] B9600   = 2'b01;
  localparam logic [1:0] B38400  = 2'b10;
  localparam logic [1:0] B115200 = 2'b11;

  localparam int DEF_DIV0 = 250000;
  localparam int DEF_DIV1 = 5208;
  localparam int DEF_DIV2 = 1302;
  localparam int DEF_DIV3 = 434;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int FRAME_BITS = 8;

  typedef struct packed {
    logic       vld;
    logic [1:0] sel;
  } cfg_req_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: a pushed entry is visible on rd_data the next cycle.
// Push while full is accepted only if a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 receive controller: synchronizer, baud config, bit timer and start/data/stop FSM feeding a FIFO.
// Byte appears on rd_data the cycle after the stop sample; full FIFO drops the byte and flags overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV0       = DEF_DIV0,
  parameter int DIV1       = DEF_DIV1,
  parameter int DIV2       = DEF_DIV2,
  parameter int DIV3       = DEF_DIV3,
  parameter int CNT_W      = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    baud_sel,
  input  logic                          cfg_load,
  input  logic                          serial_in,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic                          busy
);

  logic             rx_meta, rx_s;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] timer, div, half;
  logic [1:0]       active_sel;
  cfg_req_t         pend;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             start_hit, bit_hit, timer_clr, ret_idle;
  logic             push, stop_bad, fifo_full, fifo_empty, fifo_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    div = CNT_W'(DIV1);
    case (active_sel)
      B200:    div = CNT_W'(DIV0);
      B9600:   div = CNT_W'(DIV1);
      B38400:  div = CNT_W'(DIV2);
      B115200: div = CNT_W'(DIV3);
      default: div = CNT_W'(DIV1);
    endcase
  end

  assign half      = div >> 1;
  assign start_hit = (timer == half - CNT_W'(1));
  assign bit_hit   = (timer == div - CNT_W'(1));

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (start_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && bit_cnt == 3'(FRAME_BITS - 1)) state_nxt = STOP;
      STOP: begin
        if (bit_hit) begin
          state_nxt = IDLE;
          push      = rx_s;
          stop_bad  = !rx_s;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timer restarts on every state change and on each data-bit sample.
  assign timer_clr = (state == IDLE) || (state_nxt != state) || (state == DATA && bit_hit);
  assign ret_idle  = (state != IDLE) && (state_nxt == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_clr ? '0 : timer + CNT_W'(1);
      if (state == START) bit_cnt <= '0;
      if (state == DATA && bit_hit) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {rx_s, shreg[7:1]};
      end
    end
  end

  // Config changes while a frame is in flight wait for the return to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_sel <= B9600;
      pend       <= '0;
    end else if (state == IDLE) begin
      if (cfg_load) active_sel <= baud_sel;
      pend <= '0;
    end else if (ret_idle) begin
      if (cfg_load)      active_sel <= baud_sel;
      else if (pend.vld) active_sel <= pend.sel;
      pend <= '0;
    end else if (cfg_load) begin
      pend <= '{vld: 1'b1, sel: baud_sel};
    end
  end

  assign fifo_pop = rd_en && rd_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad | (frame_err & ~err_clr);
      overrun   <= (push & fifo_full & ~fifo_pop) | (overrun & ~err_clr);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (fifo_pop),
    .rd_data   (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid = !fifo_empty;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with shortened divisors (64/16/8/4 clocks per bit).
module tb_uart_rx_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] baud_sel;
  logic       cfg_load;
  logic       serial_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  uart_rx_ctrl #(
    .DIV0 (64),
    .DIV1 (16),
    .DIV2 (8),
    .DIV3 (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .baud_sel   (baud_sel),
    .cfg_load   (cfg_load),
    .serial_in  (serial_in),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
    serial_in = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(cpb);
    end
    serial_in = stop_bit;
    tick(cpb);
    serial_in = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    baud_sel  = 2'b01;
    cfg_load  = 1'b0;
    serial_in = 1'b1;
    rd_en     = 1'b0;
    err_clr   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_rd_valid",  32'(rd_valid),   32'd0);
    check("rst_count",     32'(fifo_count), 32'd0);
    check("rst_rd_data",   32'(rd_data),    32'h00);
    check("rst_frame_err", 32'(frame_err),  32'd0);
    check("rst_overrun",   32'(overrun),    32'd0);

    // Basic byte at default baud (16 clocks/bit)
    send_byte(8'hA5, 16, 1'b1);
    tick(2);
    check("a5_valid",     32'(rd_valid),   32'd1);
    check("a5_data",      32'(rd_data),    32'hA5);
    check("a5_count",     32'(fifo_count), 32'd1);
    check("a5_frame_err", 32'(frame_err),  32'd0);
    check("a5_overrun",   32'(overrun),    32'd0);
    pop_one();
    check("a5_popped",    32'(rd_valid),   32'd0);

    // Short low glitch: start is rejected at mid-bit
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(2);
    check("glitch_busy_hi", 32'(busy),      32'd1);
    tick(15);
    check("glitch_idle",    32'(busy),      32'd0);
    check("glitch_valid",   32'(rd_valid),  32'd0);
    check("glitch_ferr",    32'(frame_err), 32'd0);

    // Bad stop bit
    send_byte(8'h3C, 16, 1'b0);
    tick(20);
    check("ferr_set",   32'(frame_err),  32'd1);
    check("ferr_valid", 32'(rd_valid),   32'd0);
    check("ferr_count", 32'(fifo_count), 32'd0);
    clear_errs();
    check("ferr_clr",   32'(frame_err),  32'd0);

    // Five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 16, 1'b1);
    tick(2);
    check("ovr_count", 32'(fifo_count), 32'd4);
    check("ovr_flag",  32'(overrun),    32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), 32'(rd_data), 32'(i));
      pop_one();
    end
    check("ovr_empty", 32'(fifo_count), 32'd0);
    clear_errs();
    check("ovr_clr",   32'(overrun),    32'd0);

    // Baud change requested mid-frame takes effect only for the next frame
    fork
      send_byte(8'h55, 16, 1'b1);
      begin
        tick(50);
        baud_sel = 2'b11;
        cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
      end
    join
    tick(2);
    check("cfg_55_data",  32'(rd_data),    32'h55);
    check("cfg_55_count", 32'(fifo_count), 32'd1);
    send_byte(8'hF0, 4, 1'b1);
    tick(4);
    check("cfg_f0_count", 32'(fifo_count), 32'd2);
    check("cfg_f0_ferr",  32'(frame_err),  32'd0);
    pop_one();
    check("cfg_f0_data",  32'(rd_data),    32'hF0);

    // Reset during the last data bit of 0x81 (4 clocks/bit) drops frame and FIFO
    fork
      send_byte(8'h81, 4, 1'b1);
      begin
        tick(33);
        reset = 1'b1;
        tick(1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
      end
    join
    tick(10);
    check("post_rst_busy",  32'(busy),       32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_valid", 32'(rd_valid),   32'd0);
    check("post_rst_ferr",  32'(frame_err),  32'd0);
    check("post_rst_ovr",   32'(overrun),    32'd0);

    // Reset restores 16 clocks/bit
    send_byte(8'h7E, 16, 1'b1);
    tick(2);
    check("7e_data",  32'(rd_data),    32'h7E);
    check("7e_count", 32'(fifo_count), 32'd1);
    check("7e_ferr",  32'(frame_err),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
